// File: rtl/pl_fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
// Holds the fetch-state enum, PC step and counter-width helper.
package pl_fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam int PC_INC = 4;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pl_fetchq_fifo.sv
// In-order circular buffer of {instruction, pc+4} entries for the fetch queue.
// Power-of-two depth, so head/tail pointers wrap naturally.
module pl_fetchq_fifo
    import pl_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [cnt_w(DEPTH)-1:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = wdata;
                tail_d        = tail_q + 1'b1;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/pl_fetch_queue.sv
// Decoupled fetch: PC, request issue, stale-response discard and queue.
// Define PL_FETCHQ_STATS_EN to add saturating redirect/stall/empty counters.
module pl_fetch_queue
    import pl_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clrn,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc4,
    input  logic            id_ready
`ifdef PL_FETCHQ_STATS_EN
    ,
    output logic [31:0]     stat_redirects,
    output logic [31:0]     stat_stalls,
    output logic [31:0]     stat_empty
`endif
);

    localparam int              CW  = cnt_w(DEPTH);
    localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);
    localparam logic [CW:0]     CAP = (CW + 1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count;
    logic [CW:0]     reserved;
    logic [2*XLEN-1:0] head;
    logic            accept, drop, push, pop;

    assign reserved = {1'b0, count} + {1'b0, outst_q};

    // resp_pc tracks the address of the next response that will be kept
    always_comb begin
        imem_req   = ~redirect & (reserved < CAP);
        imem_addr  = fetch_pc_q;
        accept     = imem_req & imem_gnt;
        drop       = imem_rvalid & (redirect | (state_q == DRAIN));
        push       = imem_rvalid & ~drop;
        pop        = inst_valid & id_ready & ~redirect;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + INC;
        end
        unique case ({accept, imem_rvalid})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        if (push) begin
            resp_pc_d = resp_pc_q + INC;
        end
        if (imem_rvalid && discard_q != '0) begin
            discard_d = discard_q - 1'b1;
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            discard_d  = outst_d;
        end
        state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    pl_fetchq_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_rdata, resp_pc_q + INC}),
        .rdata (head),
        .count (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = head[2*XLEN-1:XLEN];
    assign inst_pc4   = head[XLEN-1:0];

    a_cap: assert property (@(posedge clk) disable iff (!clrn)
        reserved <= CAP);
    a_resp: assert property (@(posedge clk) disable iff (!clrn)
        imem_rvalid |-> (outst_q != '0));

`ifdef PL_FETCHQ_STATS_EN
    logic [31:0] red_q, red_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] empty_q, empty_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic en);
        return (en && v != '1) ? v + 32'd1 : v;
    endfunction

    always_comb begin
        red_d   = sat_inc(red_q, redirect);
        stall_d = sat_inc(stall_q, inst_valid & ~id_ready);
        empty_d = sat_inc(empty_q, ~inst_valid & ~redirect);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            red_q   <= '0;
            stall_q <= '0;
            empty_q <= '0;
        end else begin
            red_q   <= red_d;
            stall_q <= stall_d;
            empty_q <= empty_d;
        end
    end

    assign stat_redirects = red_q;
    assign stat_stalls    = stall_q;
    assign stat_empty     = empty_q;
`endif

endmodule
